// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin grant of a shared 2:1 nibble selector with a hold limit under contention
module mux2_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             y_src
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  state_t state, state_nx, other;
  logic ptr, ptr_nx, sel_nx, own_req, oth_req, beat, last;
  logic [3:0] hold_cnt, hold_nx;
  assign gnt0 = state == G0;
  assign gnt1 = state == G1;
  assign own_req = gnt1 ? req1 : req0;
  assign oth_req = gnt1 ? req0 : req1;
  assign beat = (gnt0 | gnt1) & own_req;
  assign last = hold_cnt == HOLD_LAST;
  assign other = gnt0 ? G1 : G0;
  // ptr_nx = gnt0 names the side opposite the current owner
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    hold_nx = hold_cnt;
    if (state == IDLE)
      state_nx = (req0 & req1) ? (ptr ? G1 : G0) : req0 ? G0 : req1 ? G1 : IDLE;
    else if (!own_req) begin
      state_nx = oth_req ? other : IDLE;
      ptr_nx = gnt0;
      hold_nx = '0;
    end else if (last) begin
      hold_nx = '0;
      if (oth_req) begin
        state_nx = other;
        ptr_nx = gnt0;
      end
    end else
      hold_nx = hold_cnt + 4'd1;
    sel_nx = state_nx == G1 ? 1'b1 : state_nx == G0 ? 1'b0 : sel;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      hold_cnt <= '0;
      sel <= 1'b0;
      y <= '0;
      y_valid <= 1'b0;
      y_src <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      hold_cnt <= hold_nx;
      sel <= sel_nx;
      y_valid <= beat;
      if (beat) begin
        y <= gnt1 ? d1 : d0;
        y_src <= gnt1;
      end
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: random and directed checks of two arbiter instances (MAX_HOLD 4 and 1) against a transaction-level model
module tb_mux2_rr_arbiter;
  logic clk = 0, reset_n = 0, req0 = 0, req1 = 0;
  logic [3:0] d0 = 0, d1 = 0;
  logic [1:0] g0, g1, sl, yv, ys;
  logic [3:0] yo [2];
  int checks = 0, errors = 0;
  int mh [2] = '{4, 1};
  int own [2], cnt [2], ptr_m [2], sel_m [2], yv_m [2], y_m [2], ys_m [2];

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) ua (.clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(g0[0]), .gnt1(g1[0]), .sel(sl[0]), .y(yo[0]), .y_valid(yv[0]), .y_src(ys[0]));
  mux2_rr_arbiter #(.WIDTH(4), .MAX_HOLD(1)) ub (.clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .d0(d0), .d1(d1), .gnt0(g0[1]), .gnt1(g1[1]), .sel(sl[1]), .y(yo[1]), .y_valid(yv[1]), .y_src(ys[1]));

  task automatic chk(string nm, int inst, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // Model: owner is -1 (nobody), 0 or 1; streak counts beats of the current owner
  task automatic step(int i);
    int r [2];
    int d [2];
    int o;
    r[0] = int'(req0); r[1] = int'(req1);
    d[0] = int'(d0); d[1] = int'(d1);
    yv_m[i] = 0;
    if (own[i] < 0) begin
      if (r[0] != 0 && r[1] != 0) own[i] = ptr_m[i];
      else if (r[0] != 0) own[i] = 0;
      else if (r[1] != 0) own[i] = 1;
    end else begin
      o = own[i];
      if (r[o] == 0) begin
        ptr_m[i] = 1 - o;
        cnt[i] = 0;
        own[i] = r[1-o] != 0 ? 1 - o : -1;
      end else begin
        yv_m[i] = 1; y_m[i] = d[o]; ys_m[i] = o;
        cnt[i]++;
        if (cnt[i] == mh[i]) begin
          cnt[i] = 0;
          if (r[1-o] != 0) begin own[i] = 1 - o; ptr_m[i] = 1 - o; end
        end
      end
    end
    if (own[i] >= 0) sel_m[i] = own[i];
  endtask

  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < 2; i++)
      if (!reset_n) begin
        own[i] = -1; cnt[i] = 0; ptr_m[i] = 0; sel_m[i] = 0; yv_m[i] = 0; y_m[i] = 0; ys_m[i] = 0;
      end else step(i);

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("gnt0", i, 8'(g0[i]), 8'(own[i] == 0));
      chk("gnt1", i, 8'(g1[i]), 8'(own[i] == 1));
      chk("sel", i, 8'(sl[i]), 8'(sel_m[i]));
      chk("y_valid", i, 8'(yv[i]), 8'(yv_m[i]));
      chk("y", i, 8'(yo[i]), 8'(y_m[i]));
      chk("y_src", i, 8'(ys[i]), 8'(ys_m[i]));
    end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset_n = 0; req0 = 0; req1 = 0;
    tick(2);
    reset_n = 1;
  endtask

  initial begin
    logic [15:0] pa, pb;
    pa = 16'hF0F0;
    pb = 16'hAAAA;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt1", i, 8'(g1[i]), 8'd0);
      chk("rst_yv", i, 8'(yv[i]), 8'd0);
    end
    tick(1);
    reset_n = 1;
    tick(3);
    chk("idle_gnt0", 0, 8'(g0[0]), 8'd0);
    chk("idle_yv", 0, 8'(yv[0]), 8'd0);
    // single requester, no forced switch
    req0 = 1; d0 = 3;
    tick();
    chk("single_gnt0", 0, 8'(g0[0]), 8'd1);
    for (int v = 3; v <= 8; v++) begin
      d0 = 4'(v);
      tick();
      chk("single_y", 0, 8'(yo[0]), 8'(v));
      chk("single_yv", 0, 8'(yv[0]), 8'd1);
      chk("single_src", 0, 8'(ys[0]), 8'd0);
    end
    req0 = 0;
    tick();
    chk("single_idle", 0, 8'(g0[0]), 8'd0);
    chk("single_yv0", 0, 8'(yv[0]), 8'd0);
    // tie from reset
    do_reset();
    req0 = 1; req1 = 1; d0 = 4'hA; d1 = 4'h5;
    tick();
    chk("tie_first", 0, 8'(g0[0]), 8'd1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("tie_src_a", 0, 8'(ys[0]), 8'(pa[k]));
      chk("tie_y_a", 0, 8'(yo[0]), pa[k] ? 8'h5 : 8'hA);
      chk("tie_yv_a", 0, 8'(yv[0]), 8'd1);
      chk("tie_src_b", 1, 8'(ys[1]), 8'(pb[k]));
    end
    tick(6);
    chk("mid_gnt1", 0, 8'(g1[0]), 8'd1);
    chk("mid_yv", 0, 8'(yv[0]), 8'd1);
    reset_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_gnt", i, 8'({g0[i], g1[i]}), 8'd0);
      chk("arst_sel", i, 8'(sl[i]), 8'd0);
      chk("arst_y", i, 8'({yo[i], yv[i], ys[i]}), 8'd0);
    end
    req0 = 0; req1 = 0;
    tick(2);
    reset_n = 1;
    // early release
    req1 = 1; d1 = 4'h9; d0 = 4'h2;
    tick();
    req0 = 1;
    tick(2);
    req1 = 0;
    tick();
    chk("rel_gnt0", 0, 8'(g0[0]), 8'd1);
    chk("rel_yv", 0, 8'(yv[0]), 8'd0);
    tick();
    chk("rel_y", 0, 8'(yo[0]), 8'h2);
    chk("rel_src", 0, 8'(ys[0]), 8'd0);
    // late contender
    do_reset();
    req0 = 1; d0 = 4'h7; d1 = 4'hC;
    tick(3);
    req1 = 1;
    tick(2);
    chk("late_gnt1", 0, 8'(g1[0]), 8'd1);
    chk("late_src", 0, 8'(ys[0]), 8'd0);
    tick();
    chk("late_y", 0, 8'(yo[0]), 8'hC);
    // random traffic with occasional async reset
    for (int c = 0; c < 3000; c++) begin
      req0 = $urandom_range(0, 3) != 0;
      req1 = $urandom_range(0, 2) != 0;
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      if ($urandom_range(0, 199) == 0) reset_n = 0;
      tick();
      reset_n = 1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
